// File: rtl/pattern_pkg.sv
// Shared types and pattern contents for the pattern sequence generator.
// Holds the FSM state type and the playback pattern ROM image.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PATTERN_LEN = 21;

  // Bit i holds pattern word i (LSB is word 0).
  localparam logic [PATTERN_LEN-1:0] PATTERN_INIT =
    21'b001000101101000110001;

  // Pattern bit at addr; zero past the programmed pattern.
  function automatic logic pattern_bit(
    input logic [31:0] addr
  );
    logic [PATTERN_LEN-1:0] v;
    v = PATTERN_INIT >> addr;
    return (addr < 32'(PATTERN_LEN)) ? v[0] : 1'b0;
  endfunction

endpackage

// File: rtl/pattern_seq_gen_rom.sv
// Combinational pattern ROM.
// Words beyond the pattern length read as zero.
module pattern_rom
  import pattern_pkg::*;
#(
  parameter  int DATA_W = 1,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Zero-extended pattern lookup.
  always_comb begin
    data = DATA_W'(pattern_bit(32'(addr)));
  end

endmodule

// File: rtl/pattern_seq_gen.sv
// Pattern sequence generator: plays ROM words over a valid/ready stream.
// Define PATTERN_SEQ_LOOP_EN to add the loop input for endless playback.
module pattern_seq_gen
  import pattern_pkg::*;
#(
  parameter  int DATA_W = 1,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
`ifdef PATTERN_SEQ_LOOP_EN
  input  logic              loop,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] LEN_MAX =
    (ADDR_W+1)'(DEPTH);

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W:0]   len_q, len_n;
  logic              loop_q, loop_n;
  logic              loop_in;
  logic [ADDR_W:0]   len_clip;
  logic              xfer;
  logic              last;
  logic              run_n;
  logic [DATA_W-1:0] rom_data;

`ifdef PATTERN_SEQ_LOOP_EN
  assign loop_in = loop;
`else
  assign loop_in = 1'b0;
`endif

  assign len_clip = (len > LEN_MAX) ? LEN_MAX : len;
  assign xfer     = out_valid && out_ready;
  assign last     = ({1'b0, idx} ==
                     len_q - (ADDR_W+1)'(1));

  pattern_rom #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rom (
    .addr (idx_n),
    .data (rom_data)
  );

  // Next-state, index and registered-output precompute.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_q;
    loop_n  = loop_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          len_n   = len_clip;
          idx_n   = '0;
          loop_n  = loop_in;
          state_n = (len_clip != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (xfer) begin
          if (!last) begin
            idx_n = idx + ADDR_W'(1);
          end else if (loop_q) begin
            idx_n = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (abort) begin
      state_n = IDLE;
      idx_n   = '0;
    end
    run_n = (state_n == RUN);
  end

  // State, counters and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      len_q     <= len_n;
      loop_q    <= loop_n;
      out_valid <= run_n;
      out_data  <= run_n ? rom_data : '0;
      busy      <= run_n;
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: doc/pattern_seq_gen.md
PATTERN_SEQ_GEN -- requirements
Module: pattern_seq_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 1, meaning the width of one pattern word.
REQ-002 SHALL have parameter DEPTH, default 32, meaning the number of ROM words; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin playback.
REQ-006 SHALL have port len, input, ADDR_W+1, the number of words to play; it is sampled on an accepted start.
REQ-007 SHALL have port abort, input, 1, which stops playback.
REQ-008 SHALL have ports out_data (output, DATA_W), out_valid (output, 1) and out_ready (input, 1), forming the stream handshake.
REQ-009 SHALL have port busy, output, 1, asserted while in RUN.
REQ-010 SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-011 SHALL implement the states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE; start SHALL be ignored in RUN and DONE.
REQ-013 SHALL, on an accepted start, latch len_q = min(len, DEPTH) and set idx to 0.
REQ-014 SHALL, on an accepted start, enter RUN if len_q > 0 and DONE if len_q == 0.
REQ-015 SHALL, in RUN, drive out_valid = 1 and out_data = ROM[idx]; out_data and out_valid SHALL be registered, so the first word appears one cycle after start.
REQ-016 SHALL complete a transfer only on a cycle where out_valid && out_ready.
REQ-017 SHALL keep out_data stable while out_valid && !out_ready.
REQ-018 SHALL, on a transfer with idx < len_q-1, increment idx.
REQ-019 SHALL, on a transfer with idx == len_q-1, go to DONE; when looping is enabled (REQ-027), it SHALL instead wrap idx to 0 and stay in RUN with no bubble.
REQ-020 SHALL, in DONE, assert done for exactly one cycle with out_valid = 0, then go to IDLE.
REQ-021 SHALL, when abort is high in any state, go to IDLE next cycle with out_valid = 0 and no done pulse; abort SHALL take priority over a simultaneous transfer or start.
REQ-022 SHALL drive out_data = 0 whenever out_valid = 0.
REQ-023 SHALL return 0 for ROM addresses at or above the programmed pattern length.

Reset
REQ-024 SHALL, when rst is high at a clock edge, set state = IDLE, idx = 0, len_q = 0, out_valid = 0, out_data = 0, busy = 0 and done = 0.
REQ-025 SHALL give rst priority over abort, start and the handshake; a reset mid-RUN SHALL drop out_valid on the next cycle with no done pulse.

Configuration
REQ-026 SHALL support loop mode through the macro PATTERN_SEQ_LOOP_EN.
REQ-027 SHALL, with PATTERN_SEQ_LOOP_EN defined, add an input loop (1 bit) sampled at start; if loop_q = 1, the REQ-019 wrap applies and playback ends only on abort or rst.
REQ-028 SHALL, without PATTERN_SEQ_LOOP_EN, have no loop port, and every playback SHALL end in DONE.

Structure
REQ-029 SHALL take from the shared package pattern_pkg: the state enum type, PATTERN_LEN, and the constant pattern array PATTERN_INIT (default DATA_W=1 contents, idx 0..20: 1,0,0,0,1,1,0,0,0,1,0,1,1,0,1,0,0,0,1,0,0).
REQ-030 SHALL place the ROM in one combinational sub-module, pattern_rom (parameters DATA_W, DEPTH; ports addr -> data), initialised from PATTERN_INIT.

Verification
REQ-031 SHALL verify basic playback: len=5, out_ready held 1, pulse start -> out_data 1,0,0,0,1 on 5 consecutive cycles, then done=1 for one cycle, busy=0.
REQ-032 SHALL verify backpressure: len=3, out_ready toggled 1,0,0,1,1 -> word 0 is held stable during the stall, sequence is 1,0,0, no word is duplicated or dropped.
REQ-033 SHALL verify the boundaries: len=0 -> done one cycle after start and out_valid never asserted; len=40 with DEPTH=32 -> exactly 32 words, words 21..31 are 0.
REQ-034 SHALL verify abort and reset: abort on the 3rd word -> IDLE, no done pulse, and a following start plays from idx 0; rst mid-RUN -> all outputs 0 on the next cycle.
REQ-035 SHALL verify loop mode (PATTERN_SEQ_LOOP_EN, loop=1, len=4): the stream is 1,0,0,0,1,0,0,0,... with no bubble and no done pulse until abort.
REQ-036 SHALL verify start while busy: a second start during RUN is ignored, and len_q and idx are unchanged.
